// File: rtl/pmodadc_pkg.sv
// Shared definitions for the PmodADC reader and the 16-bit shift-out stage.
// Frame layout: 4 leading zeros, then a 12-bit sample MSB-first.
package pmodadc_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_LEAD_BITS  = 4;
  localparam int SAMPLE_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter; tick_o is high for the single cycle in which
// the count equals SAMPLE_PERIOD-1.
module tick_gen #(
  parameter int SAMPLE_PERIOD = 272
) (
  input  logic clk_i,
  input  logic reset_ni,
  output logic tick_o
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/adc_spi_reader.sv
// Periodic SPI master for an AD7476-style ADC. One 16-bit frame per enabled
// period tick; the sample is presented left-justified on data_o.
module adc_spi_reader
  import pmodadc_pkg::*;
#(
  parameter int CLK_DIV           = 2,
  parameter int SAMPLE_PERIOD     = 272,
  parameter bit SKIP_PERIOD_CHECK = 1'b0
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                enable_i,
  input  logic                sdata_i,
  output logic                cs_no,
  output logic                sclk_o,
  output logic [SAMPLE_W-1:0] data_o,
  output logic                data_rdy_o,
  output logic                frame_err_o,
  output logic                overrun_o,
  output state_e              state_o
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("adc_spi_reader: CLK_DIV must be at least 2");
  end
  if (!SKIP_PERIOD_CHECK && (SAMPLE_PERIOD < 33 * CLK_DIV + 2)) begin : g_bad_period
    $error("adc_spi_reader: SAMPLE_PERIOD too short for one frame");
  end

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int BIT_W = $clog2(ADC_FRAME_BITS + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADC_FRAME_BITS);

  state_e                    state_q, state_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [BIT_W-1:0]          bits_q, bits_d;
  logic [ADC_FRAME_BITS-1:0] sr_q, sr_d;
  logic [SAMPLE_W-1:0]       data_q, data_d;
  logic                      cs_q, cs_d, sclk_q, sclk_d;
  logic                      rdy_q, rdy_d, err_q, err_d, ovr_q, ovr_d;
  logic                      tick, div_done;

  tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .tick_o  (tick)
  );

  assign div_done = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bits_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bits_q  <= bits_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // SCLK falls on entry to LOW (ADC shifts out), rises on entry to HIGH,
  // which is also when sdata_i is captured: a full half-period after the fall.
  always_comb begin
    state_d = state_q;
    div_d   = div_q + DIV_W'(1);
    bits_d  = bits_q;
    sr_d    = sr_q;
    data_d  = data_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    rdy_d   = 1'b0;
    err_d   = err_q;
    ovr_d   = ovr_q | (tick && (state_q != ST_IDLE));
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (tick && enable_i) begin
          cs_d    = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_done) begin
          div_d   = '0;
          sclk_d  = 1'b0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (div_done) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          sr_d    = {sr_q[ADC_FRAME_BITS-2:0], sdata_i};
          bits_d  = bits_q + BIT_W'(1);
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (div_done) begin
          div_d = '0;
          if (bits_q == BIT_LAST) begin
            cs_d    = 1'b1;
            data_d  = {sr_q[ADC_DATA_BITS-1:0], {ADC_LEAD_BITS{1'b0}}};
            err_d   = |sr_q[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS];
            rdy_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            sclk_d  = 1'b0;
            state_d = ST_LOW;
          end
        end
      end
      ST_DONE: begin
        div_d   = '0;
        bits_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        bits_d  = '0;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        err_d   = 1'b0;
        ovr_d   = ovr_q;
      end
    endcase
  end

  // data_rdy_o is a single-cycle strobe with no back-pressure: data_o and
  // frame_err_o are valid from that cycle until the next strobe.
  assign cs_no       = cs_q;
  assign sclk_o      = sclk_q;
  assign data_o      = data_q;
  assign data_rdy_o  = rdy_q;
  assign frame_err_o = err_q;
  assign overrun_o   = ovr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader: ADC and 74HC595 models, a per-cycle
// frame-level model, and an overrun instance with a short period.
module tb_adc_spi_reader;
  import pmodadc_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 272;
  localparam int FRAME_C = 33 * CLK_DIV;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_ni = 1'b0, enable = 1'b0, sdata = 1'b0;
  logic        cs_n, sclk, rdy, ferr, ovr;
  logic [15:0] data;
  state_e      state;

  logic        r2_ni = 1'b0, en2 = 1'b1, sdata2 = 1'b0;
  logic        cs2_n, sclk2, rdy2, ferr2, ovr2;
  logic [15:0] data2;
  state_e      state2;

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD)) u_dut (
    .clk_i(clk), .reset_ni(reset_ni), .enable_i(enable), .sdata_i(sdata),
    .cs_no(cs_n), .sclk_o(sclk), .data_o(data), .data_rdy_o(rdy),
    .frame_err_o(ferr), .overrun_o(ovr), .state_o(state)
  );

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(60), .SKIP_PERIOD_CHECK(1'b1)) u_ovr (
    .clk_i(clk), .reset_ni(r2_ni), .enable_i(en2), .sdata_i(sdata2),
    .cs_no(cs2_n), .sclk_o(sclk2), .data_o(data2), .data_rdy_o(rdy2),
    .frame_err_o(ferr2), .overrun_o(ovr2), .state_o(state2)
  );

  int cyc = 0, cyc2 = 0;
  always @(posedge clk) if (!reset_ni) cyc <= 0; else cyc <= cyc + 1;
  always @(posedge clk) if (!r2_ni) cyc2 <= 0; else cyc2 <= cyc2 + 1;

  int n_vec = 0, n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ADC model: word taken at CS fall, one bit presented per SCLK fall.
  logic [15:0] adc_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur_word = '0;
  int          bit_idx = 0;

  always @(negedge cs_n) begin
    cur_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
    exp_q.push_back(cur_word);
    bit_idx = 0;
  end
  always @(negedge sclk) begin
    if (!cs_n && bit_idx < 16) begin
      sdata = cur_word[15 - bit_idx];
      bit_idx++;
    end
  end
  always @(negedge reset_ni) exp_q.delete();

  // 74HC595 model: latches data_o on the rising edge of data_rdy_o.
  logic [15:0] hc_q[$];
  always @(posedge rdy) begin
    #1;
    hc_q.push_back(data);
  end

  // scoreboard / compare process
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_rdy = 1'b0, fall;
  int          fall_cyc = 0, low_cnt = 0, rise_cnt = 0, rdy_cnt = 0, fall_cnt = 0;
  logic [15:0] model_data = '0, w;
  logic        model_err = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!reset_ni) begin
      chk("rst_cs_n", cs_n, 1); chk("rst_sclk", sclk, 1); chk("rst_data", data, 0);
      chk("rst_rdy", rdy, 0); chk("rst_err", ferr, 0); chk("rst_ovr", ovr, 0);
      model_data = '0;
      model_err  = 1'b0;
    end else begin
      fall = prev_cs && !cs_n;
      chk("cs_fall_on_tick", fall, (cyc % PERIOD == 0) && (cyc > 0) && enable);
      if (fall) begin
        fall_cyc = cyc; low_cnt = 0; rise_cnt = 0; fall_cnt++;
      end
      if (!cs_n) low_cnt++;
      if (!cs_n && !prev_sclk && sclk) rise_cnt++;
      if (rdy) begin
        rdy_cnt++;
        chk("rdy_one_cycle", prev_rdy, 0);
        chk("rdy_latency", cyc - fall_cyc, FRAME_C);
        chk("cs_low_cycles", low_cnt, FRAME_C);
        chk("sclk_rises", rise_cnt, 16);
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rdy_unexpected: pulse with no frame outstanding (cycle %0d)", cyc);
        end else begin
          w = exp_q.pop_front();
          model_data = {w[11:0], 4'h0};
          model_err  = (w[15:12] != 4'h0);
        end
      end
      chk("data_o", data, model_data);
      chk("frame_err", ferr, model_err);
      chk("overrun_main", ovr, 0);
    end
    prev_cs = cs_n; prev_sclk = sclk; prev_rdy = rdy;
  end

  // driver tasks
  task automatic wait_cs_fall(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!cs_n) break;
    end
    if (k == budget) begin
      n_vec++; n_err++;
      $display("FAIL wait_cs_fall: no CS fall within %0d cycles", budget);
    end
  endtask

  task automatic wait_rdy(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (rdy) break;
    end
    if (k == budget) begin
      n_vec++; n_err++;
      $display("FAIL wait_rdy: no data_rdy pulse within %0d cycles", budget);
    end
  endtask

  int snap;

  initial begin
    adc_q = '{16'h0ABC, 16'h8FFF, 16'h0001, 16'h0123, 16'h0456,
              16'h0777, 16'h0F0F, 16'h0555, 16'h0A5A};

    // overrun instance: ticks at 59,119,179,239; frames complete at 126, 246
    repeat (2) @(negedge clk);
    r2_ni = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      chk("ovr_rdy", rdy2, (cyc2 == 126) || (cyc2 == 246));
      chk("ovr_flag", ovr2, cyc2 >= 120);
    end
    chk("ovr_data", data2, 16'h0000);
    chk("ovr_frame_err", ferr2, 0);

    // main instance
    enable = 1'b1;
    @(negedge clk);
    reset_ni = 1'b1;

    wait_cs_fall(400);
    chk("f1_cs_fall_cycle", cyc, 272);
    wait_rdy(100);
    chk("f1_rdy_cycle", cyc, 338);
    chk("f1_data", data, 16'hABC0);
    chk("f1_err", ferr, 0);
    @(posedge clk); #1;
    chk("f1_rdy_low_after", rdy, 0);

    wait_rdy(400);
    chk("f2_data", data, 16'hFFF0);
    chk("f2_err", ferr, 1);
    wait_rdy(400);
    chk("f3_data", data, 16'h0010);
    chk("f3_err", ferr, 0);

    wait_rdy(400);
    wait_rdy(400);
    @(negedge clk);
    chk("hc595_count", hc_q.size(), 5);
    chk("hc595_latch_a", hc_q[3], 16'h1230);
    chk("hc595_latch_b", hc_q[4], 16'h4560);

    // enable dropped mid-frame
    wait_cs_fall(400);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_rdy(100);
    chk("f6_data", data, 16'h7770);
    snap = fall_cnt;
    repeat (600) @(posedge clk);
    #1;
    chk("no_start_while_disabled", fall_cnt, snap);
    @(negedge clk);
    enable = 1'b1;
    wait_cs_fall(300);
    chk("resume_on_tick", cyc % PERIOD, 0);
    wait_rdy(100);
    chk("f7_data", data, 16'hF0F0);
    chk("f7_err", ferr, 0);

    // reset after bit 7 of a frame
    wait_cs_fall(400);
    repeat (34) @(posedge clk);
    @(negedge clk);
    reset_ni = 1'b0;
    #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sclk", sclk, 1);
    chk("midrst_data", data, 16'h0000);
    chk("midrst_rdy", rdy, 0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    wait_cs_fall(300);
    chk("post_rst_cs_fall_cycle", cyc, 272);
    wait_rdy(100);
    chk("f9_data", data, 16'hA5A0);
    chk("f9_err", ferr, 0);

    @(negedge clk);
    chk("rdy_total", rdy_cnt, 8);
    chk("hc595_total", hc_q.size(), 8);
    chk("ovr_sticky_end", ovr2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
